// File: rtl/johnson_pkg.sv
// johnson_pkg: shared definitions for the Johnson sequence controller.
//   - default WIDTH / DIV_W values
//   - cmd_op encodings
//   - FSM state type and state constants
//   - eff_len(): maps the 3-bit cmd_len field to an effective ring length L
package johnson_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV_W = 8;

  localparam logic [1:0] OP_STOP  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_STEP = 2'd2;

  // L = cmd_len + 1, except that a one-bit ring is meaningless, so 0 maps to L = 2.
  function automatic logic [3:0] eff_len(input logic [2:0] cmd_len);
    if (cmd_len == 3'd0) begin
      return 4'd2;
    end
    return {1'b0, cmd_len} + 4'd1;
  endfunction

endpackage

// File: rtl/johnson_core.sv
// johnson_core: Johnson pattern register with variable active length.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   adv           - advance the pattern by one Johnson step this edge
//   dir           - 0 = shift left, 1 = shift right
//   len           - active length L (2..WIDTH); bits at index >= L are held at 0
//   clr           - force pattern to 0 (takes priority over adv, never pulses wrap)
//   pattern       - registered pattern
//   wrap          - registered one-cycle pulse when an advance produced all-zero
module johnson_core #(
  parameter int WIDTH = johnson_pkg::DEF_WIDTH,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             dir,
  input  logic [LEN_W-1:0] len,
  input  logic             clr,
  output logic [WIDTH-1:0] pattern,
  output logic             wrap
);

  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] adv_pat;
  logic             msb;

  // p[L-1] with a run-time L; a loop compare avoids a dynamic part-select.
  always_comb begin
    msb = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i + 1 == int'(len)) begin
        msb = pattern_q[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic l_bit;
      logic r_bit;

      // Left: bit 0 takes ~p[L-1], others take their lower neighbour.
      if (gi == 0) begin : g_l_lsb
        assign l_bit = ~msb;
      end else begin : g_l_mid
        assign l_bit = pattern_q[gi-1];
      end

      // Right: bit L-1 takes ~p[0], others take their upper neighbour.
      // The top bit can only be L-1 when L == WIDTH.
      if (gi == WIDTH - 1) begin : g_r_top
        assign r_bit = ~pattern_q[0];
      end else begin : g_r_mid
        assign r_bit = (gi + 1 == int'(len)) ? ~pattern_q[0] : pattern_q[gi+1];
      end

      assign adv_pat[gi] = (gi < int'(len)) ? (dir ? r_bit : l_bit) : 1'b0;
    end
  endgenerate

  always_comb begin
    pattern_d = pattern_q;
    wrap_d    = 1'b0;
    if (clr) begin
      pattern_d = '0;
    end else if (adv) begin
      pattern_d = adv_pat;
      wrap_d    = (adv_pat == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      wrap_q    <= wrap_d;
    end
  end

  assign pattern = pattern_q;
  assign wrap    = wrap_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: command-driven Johnson sequence generator.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   cmd_valid/cmd_ready   - command handshake (accept when both are 1)
//   cmd_op                - STOP / RUN / STEP / CLEAR
//   cmd_len, cmd_dir      - ring length code and shift direction
//   cmd_div               - advance once every cmd_div+1 cycles
//   cmd_count             - number of advances for STEP
//   pattern               - registered Johnson pattern
//   busy                  - 1 in RUN or STEP
//   done                  - one-cycle pulse when STEP completes
//   wrap                  - one-cycle pulse when an advance returns pattern to 0
module johnson_seq_ctrl #(
  parameter int WIDTH = johnson_pkg::DEF_WIDTH,
  parameter int DIV_W = johnson_pkg::DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_len,
  input  logic             cmd_dir,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic [DIV_W-1:0] cmd_count,
  output logic [WIDTH-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  import johnson_pkg::*;

  localparam int LEN_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             done_q, done_d;

  logic             accept;
  logic             adv;
  logic             clr;
  logic [3:0]       req_len4;
  logic [LEN_W-1:0] req_len;

  assign cmd_ready = ~rst & (state_q != ST_STEP);
  assign accept    = cmd_valid & cmd_ready;

  // Effective length of the offered command, clamped to the physical ring.
  always_comb begin
    req_len4 = eff_len(cmd_len);
    if (int'(req_len4) > WIDTH) begin
      req_len = LEN_W'(WIDTH);
    end else begin
      req_len = LEN_W'(req_len4);
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    dir_d   = dir_q;
    div_d   = div_q;
    count_d = count_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    adv     = 1'b0;
    clr     = 1'b0;

    if (accept) begin
      // An accepting edge never advances; the new prescale period starts here.
      presc_d = cmd_div;
      unique case (cmd_op)
        OP_STOP: begin
          state_d = ST_IDLE;
        end
        OP_CLEAR: begin
          state_d = ST_IDLE;
          clr     = 1'b1;
        end
        default: begin
          // RUN or STEP: keep the pattern unless the ring length changes.
          clr     = (req_len != len_q);
          len_d   = req_len;
          dir_d   = cmd_dir;
          div_d   = cmd_div;
          if (cmd_op == OP_STEP) begin
            count_d = cmd_count;
            state_d = ST_STEP;
          end else begin
            state_d = ST_RUN;
          end
        end
      endcase
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (presc_q == '0) begin
            adv     = 1'b1;
            presc_d = div_q;
          end else begin
            presc_d = presc_q - DIV_W'(1);
          end
        end
        ST_STEP: begin
          if (count_q == '0) begin
            // Zero-length STEP (or already exhausted): finish without advancing.
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (presc_q == '0) begin
            adv     = 1'b1;
            presc_d = div_q;
            count_d = count_q - DIV_W'(1);
            if (count_q == DIV_W'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q - DIV_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= LEN_W'(WIDTH);
      dir_q   <= 1'b0;
      div_q   <= '0;
      count_q <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      div_q   <= div_d;
      count_q <= count_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  johnson_core #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .adv     (adv),
    .dir     (dir_d),
    .len     (len_d),
    .clr     (clr),
    .pattern (pattern),
    .wrap    (wrap)
  );

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Testbench for johnson_seq_ctrl: directed scenarios with constant expectations,
// then randomized commands checked against a cycle-level reference model that
// works from "edges since accept" arithmetic and the Johnson shift rules.
module tb_johnson_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_len;
  logic       cmd_dir;
  logic [7:0] cmd_div;
  logic [7:0] cmd_count;
  logic [7:0] pattern;
  logic       busy;
  logic       done;
  logic       wrap;

  int n_cmp  = 0;
  int n_fail = 0;

  johnson_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_dir   (cmd_dir),
    .cmd_div   (cmd_div),
    .cmd_count (cmd_count),
    .pattern   (pattern),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_state;   // 0 idle, 1 run, 2 step
  int m_L;
  int m_dir;
  int m_div;
  int m_cnt;
  int m_t;       // edges since the accepting edge
  int m_pat;
  bit m_done;
  bit m_wrap;

  function automatic int johnson_next(int p, int L, int d);
    if (d == 0) return ((p << 1) | (((p >> (L - 1)) & 1) ^ 1)) & ((1 << L) - 1);
    return (p >> 1) | (((p & 1) ^ 1) << (L - 1));
  endfunction

  function automatic void model_edge();
    int L;
    m_done = 1'b0;
    m_wrap = 1'b0;
    L = (cmd_len == 3'd0) ? 2 : int'(cmd_len) + 1;
    if (rst) begin
      m_state = 0; m_pat = 0; m_L = 8; m_dir = 0; m_div = 0; m_cnt = 0; m_t = 0;
    end else if (cmd_valid && m_state != 2) begin
      m_t = 0;
      case (cmd_op)
        2'b00: m_state = 0;
        2'b11: begin m_state = 0; m_pat = 0; end
        default: begin
          if (L != m_L) m_pat = 0;
          m_L = L; m_dir = int'(cmd_dir); m_div = int'(cmd_div);
          if (cmd_op == 2'b10) begin m_cnt = int'(cmd_count); m_state = 2; end
          else m_state = 1;
        end
      endcase
    end else if (m_state != 0) begin
      m_t++;
      if (m_state == 2 && m_cnt == 0) begin
        m_state = 0; m_done = 1'b1;
      end else if (m_t % (m_div + 1) == 0) begin
        m_pat  = johnson_next(m_pat, m_L, m_dir);
        m_wrap = (m_pat == 0);
        if (m_state == 2 && m_t / (m_div + 1) == m_cnt) begin
          m_state = 0; m_done = 1'b1;
        end
      end
    end
  endfunction

  // One clock: update the model with the inputs present at this edge, then
  // land 1 time unit after the edge for sampling.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] len, input logic dir,
                      input logic [7:0] div, input logic [7:0] cnt);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_dir = dir;
    cmd_div = div; cmd_count = cnt;
    $display("cmd: op=%0d len=%0d dir=%0d div=%0d count=%0d", op, len, dir, div, cnt);
    cyc();
    cmd_valid = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b01;
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst: got %b expected 0", cmd_ready); end
    cyc(); cyc();
    n_cmp++; if ({busy, done, wrap, pattern} !== 11'd0) begin n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b wrap=%b pattern=%02h expected all 0", busy, done, wrap, pattern); end
    rst = 1'b0; cmd_valid = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_run_left();
    logic [7:0] exp_seq [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E, 8'h0C, 8'h08, 8'h00};
    send(2'b11, 3'd0, 1'b0, 8'd0, 8'd0);
    send(2'b01, 3'd3, 1'b0, 8'd0, 8'd0);
    n_cmp++; if (pattern !== 8'h00 || busy !== 1'b1) begin n_fail++;
      $display("FAIL run_left_accept: got pattern=%02h busy=%b expected 00 1", pattern, busy); end
    for (int i = 0; i < 8; i++) begin
      cyc();
      n_cmp++; if (pattern !== exp_seq[i] || wrap !== (i == 7)) begin n_fail++;
        $display("FAIL run_left[%0d]: got pattern=%02h wrap=%b expected %02h %b", i, pattern, wrap, exp_seq[i], i == 7); end
    end
    send(2'b00, 3'd3, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_step();
    send(2'b11, 3'd0, 1'b0, 8'd0, 8'd0);
    send(2'b10, 3'd7, 1'b0, 8'd2, 8'd5);
    n_cmp++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin n_fail++;
      $display("FAIL step_accept: got ready=%b busy=%b expected 0 1", cmd_ready, busy); end
    for (int e = 1; e <= 15; e++) begin
      logic [7:0] exp_p;
      exp_p = 8'((1 << (e / 3)) - 1);
      cyc();
      n_cmp++; if (pattern !== exp_p || done !== (e == 15) || cmd_ready !== (e == 15)) begin n_fail++;
        $display("FAIL step_edge%0d: got pattern=%02h done=%b ready=%b expected %02h %b %b",
                 e, pattern, done, cmd_ready, exp_p, e == 15, e == 15); end
    end
    n_cmp++; if (pattern !== 8'h1F || busy !== 1'b0) begin n_fail++;
      $display("FAIL step_final: got pattern=%02h busy=%b expected 1F 0", pattern, busy); end
  endtask

  task automatic test_step_zero();
    send(2'b10, 3'd7, 1'b1, 8'd5, 8'd0);
    n_cmp++; if (cmd_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin n_fail++;
      $display("FAIL step0_accept: got ready=%b busy=%b done=%b expected 0 1 0", cmd_ready, busy, done); end
    cyc();
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || pattern !== 8'h1F) begin n_fail++;
      $display("FAIL step0_edge1: got done=%b busy=%b ready=%b pattern=%02h expected 1 0 1 1F", done, busy, cmd_ready, pattern); end
    cyc();
    n_cmp++; if (done !== 1'b0 || pattern !== 8'h1F) begin n_fail++;
      $display("FAIL step0_edge2: got done=%b pattern=%02h expected 0 1F", done, pattern); end
  endtask

  task automatic test_run_right_stop_clear();
    logic [7:0] exp_seq [10] = '{8'h08, 8'h0C, 8'h0E, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h08, 8'h0C};
    send(2'b11, 3'd0, 1'b0, 8'd0, 8'd0);
    send(2'b01, 3'd3, 1'b1, 8'd0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++; if (pattern !== exp_seq[i] || wrap !== (i == 7)) begin n_fail++;
        $display("FAIL run_right[%0d]: got pattern=%02h wrap=%b expected %02h %b", i, pattern, wrap, exp_seq[i], i == 7); end
    end
    send(2'b00, 3'd0, 1'b0, 8'd0, 8'd0);
    cyc(); cyc(); cyc();
    n_cmp++; if (pattern !== 8'h0C || busy !== 1'b0) begin n_fail++;
      $display("FAIL stop_hold: got pattern=%02h busy=%b expected 0C 0", pattern, busy); end
    send(2'b11, 3'd0, 1'b0, 8'd0, 8'd0);
    n_cmp++; if (pattern !== 8'h00 || wrap !== 1'b0) begin n_fail++;
      $display("FAIL clear: got pattern=%02h wrap=%b expected 00 0", pattern, wrap); end
  endtask

  task automatic test_len0();
    logic [7:0] exp_seq [9] = '{8'h01, 8'h03, 8'h02, 8'h00, 8'h01, 8'h03, 8'h02, 8'h00, 8'h01};
    send(2'b01, 3'd0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 9; i++) begin
      cyc();
      n_cmp++; if (pattern !== exp_seq[i] || wrap !== (i == 3 || i == 7)) begin n_fail++;
        $display("FAIL len0[%0d]: got pattern=%02h wrap=%b expected %02h %b", i, pattern, wrap, exp_seq[i], i == 3 || i == 7); end
    end
    send(2'b01, 3'd5, 1'b0, 8'd0, 8'd0);
    n_cmp++; if (pattern !== 8'h00) begin n_fail++;
      $display("FAIL len_change_clear: got pattern=%02h expected 00", pattern); end
    cyc();
    n_cmp++; if (pattern !== 8'h01) begin n_fail++;
      $display("FAIL len_change_adv: got pattern=%02h expected 01", pattern); end
    send(2'b00, 3'd0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_reset_mid_step();
    send(2'b11, 3'd0, 1'b0, 8'd0, 8'd0);
    send(2'b10, 3'd7, 1'b0, 8'd0, 8'd10);
    cyc(); cyc(); cyc();
    n_cmp++; if (pattern !== 8'h07 || busy !== 1'b1) begin n_fail++;
      $display("FAIL midstep_pre: got pattern=%02h busy=%b expected 07 1", pattern, busy); end
    rst = 1'b1;
    cyc();
    n_cmp++; if (pattern !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin n_fail++;
      $display("FAIL midstep_rst: got pattern=%02h busy=%b done=%b wrap=%b expected 00 0 0 0", pattern, busy, done, wrap); end
    rst = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL midstep_ready: got %b expected 1", cmd_ready); end
    for (int i = 0; i < 12; i++) begin
      cyc();
      n_cmp++; if (done !== 1'b0 || pattern !== 8'h00) begin n_fail++;
        $display("FAIL midstep_after[%0d]: got done=%b pattern=%02h expected 0 00", i, done, pattern); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      cmd_valid = ($urandom_range(0, 4) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_len   = 3'($urandom_range(0, 7));
      cmd_dir   = 1'($urandom_range(0, 1));
      cmd_div   = 8'($urandom_range(0, 3));
      cmd_count = 8'($urandom_range(0, 6));
      #1;
      n_cmp++; if (cmd_ready !== (!rst && m_state != 2)) begin n_fail++;
        $display("FAIL rand_ready[%0d]: got %b expected %b", i, cmd_ready, !rst && m_state != 2); end
      if (cmd_valid && cmd_ready && !rst)
        $display("rand cmd[%0d]: op=%0d len=%0d dir=%0d div=%0d count=%0d", i, cmd_op, cmd_len, cmd_dir, cmd_div, cmd_count);
      cyc();
      n_cmp++;
      if (pattern !== 8'(m_pat) || busy !== (m_state != 0) || done !== m_done || wrap !== m_wrap) begin n_fail++;
        $display("FAIL rand_out[%0d]: got pattern=%02h busy=%b done=%b wrap=%b expected %02h %b %b %b",
                 i, pattern, busy, done, wrap, 8'(m_pat), m_state != 0, m_done, m_wrap); end
    end
    rst = 1'b0; cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 3'd0;
    cmd_dir = 1'b0; cmd_div = 8'd0; cmd_count = 8'd0;
    test_reset();
    test_run_left();
    test_step();
    test_step_zero();
    test_run_right_stop_clear();
    test_len0();
    test_reset_mid_step();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/johnson_seq_ctrl.md
JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning maximum Johnson ring length and pattern width.
REQ-002 SHALL have parameter DIV_W, default 8, meaning prescaler and step-count width.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-005 SHALL have port rst, input, 1, meaning the synchronous active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1, meaning a command is offered.
REQ-007 SHALL have port cmd_ready, output, 1, meaning a command can be accepted.
REQ-008 SHALL have port cmd_op, input, 2, meaning 00 STOP, 01 RUN, 10 STEP, 11 CLEAR.
REQ-009 SHALL have port cmd_len, input, 3, meaning active length L = cmd_len+1, with 0 coerced to L=2.
REQ-010 SHALL have port cmd_dir, input, 1, meaning 0 shift-left, 1 shift-right.
REQ-011 SHALL have port cmd_div, input, DIV_W, meaning advance once every cmd_div+1 cycles.
REQ-012 SHALL have port cmd_count, input, DIV_W, meaning number of advances for STEP.
REQ-013 SHALL have port pattern, output, WIDTH, meaning the registered Johnson pattern.
REQ-014 SHALL have port busy, output, 1, meaning the FSM is in RUN or STEP.
REQ-015 SHALL have port done, output, 1, meaning a one-cycle pulse when STEP completes.
REQ-016 SHALL have port wrap, output, 1, meaning a one-cycle pulse when an advance returns pattern to all-zero.

Function
REQ-017 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-018 cmd_ready SHALL be 1 in IDLE and RUN, 0 in STEP, and 0 while rst is 1.
REQ-019 The FSM SHALL have three states: IDLE, RUN and STEP.
REQ-020 On accept, STOP SHALL go to IDLE and hold pattern.
REQ-021 On accept, CLEAR SHALL go to IDLE and set pattern to 0.
REQ-022 On accept, RUN SHALL go to RUN and latch len, dir and div.
REQ-023 On accept, STEP SHALL go to STEP and latch len, dir, div and count.
REQ-024 On any RUN or STEP accept whose effective L differs from the current L, pattern SHALL clear to 0; otherwise pattern SHALL be kept, including on a direction change.
REQ-025 The prescaler SHALL load cmd_div on accept; in RUN or STEP, when it is 0 the block SHALL advance the pattern and reload div, otherwise it SHALL decrement.
REQ-026 The first advance SHALL occur on the (div+1)th edge after the accepting edge.
REQ-027 A left advance SHALL set p[L-1:0] to {p[L-2:0], ~p[L-1]}.
REQ-028 A right advance SHALL set p[L-1:0] to {~p[0], p[L-1:1]}.
REQ-029 Pattern bits at index L and above SHALL always be 0.
REQ-030 Period SHALL be 2L advances.
REQ-031 wrap SHALL be registered and pulse in the cycle the advanced pattern becomes 0.
REQ-032 In STEP, after the count-th advance the FSM SHALL return to IDLE on that same edge, and done SHALL pulse coincident with the final pattern value.
REQ-033 A STEP with count=0 SHALL make no advance, pulse done on the edge after accept, and return to IDLE.
REQ-034 RUN SHALL continue indefinitely; a RUN accepted while in RUN SHALL reload config and prescaler without a pattern glitch.
REQ-035 cmd_valid while cmd_ready=0 SHALL be ignored; the command SHALL NOT be queued.

Reset
REQ-036 With rst=1 at an edge: pattern=0, state=IDLE, busy=0, done=0, wrap=0, latched len=8 (L=WIDTH), dir=0, div=0, count=0.
REQ-037 Reset mid-STEP or mid-RUN SHALL abort with no done or wrap pulse; cmd_ready SHALL be 1 in the first cycle after rst falls.

Structure
REQ-038 Package johnson_pkg SHALL hold the cmd_op encodings, the FSM state type, and the WIDTH and DIV_W defaults.
REQ-039 Sub-module johnson_core SHALL hold the pattern register, with inputs adv, dir, len and clr and outputs pattern and wrap.
REQ-040 johnson_seq_ctrl SHALL hold the FSM, prescaler, step counter and handshake.

Verification
REQ-041 Reset, then RUN len=3 div=0 dir=0 -> pattern 00,01,03,07,0F,0E,0C,08,00 on consecutive edges, wrap on the 8th advance, bits 7:4 always 0.
REQ-042 STEP count=5 div=2 len=7 dir=0 from 0 -> advances at edges 3,6,9,12,15 after accept, final pattern 0x1F, single done at edge 15, cmd_ready=0 throughout.
REQ-043 STEP count=0 -> no pattern change, done pulses on edge 1, cmd_ready=1 again on the next cycle.
REQ-044 RUN len=3 dir=1 div=0 from 0 -> 08,0C,0E,0F,07,03,01,00; then STOP holds the value and CLEAR gives 0.
REQ-045 cmd_len=0 RUN -> 00,01,03,02,00 with wrap every 4 advances; then RUN len=5 clears pattern to 0.
REQ-046 rst asserted mid-STEP at count 3 of 10 -> pattern=0, busy=0, no done, cmd_ready=1 the cycle after release.
